// File: rtl/multihat_pkg.sv
// Shared constants, FSM state type and LFSR/seed helpers for the multi-hat
// Gaussian generator.
package multihat_pkg;

  localparam logic [31:0] LFSR_POLY  = 32'h80200003;
  localparam logic [31:0] SEED_GOLD  = 32'h9E3779B9;
  localparam int unsigned OUT_OFFSET = 32768;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

  // Per-hat seed decorrelation; an all-zero LFSR would lock up, so map it to 1.
  function automatic logic [31:0] hat_seed(input logic [31:0] seed, input int unsigned h);
    logic [31:0] v;
    v = seed ^ (32'(h) * SEED_GOLD);
    return (v == '0) ? 32'h1 : v;
  endfunction

endpackage

// File: rtl/multihat_if.sv
// Output stream bundle (valid/ready/data) for the multi-hat generator.
interface multihat_if #(parameter int N_CH = 4);
  logic                 out_valid;
  logic                 out_ready;
  logic [16*N_CH-1:0]   out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/multihat_lfsr.sv
// One 32-bit Galois LFSR "hat": reset seed, synchronous load, advance or hold.
module multihat_lfsr import multihat_pkg::*; #(
  parameter logic [31:0] RST_SEED = 32'h1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [31:0] i_seed,
  input  logic        i_adv,
  output logic [15:0] o_uni
);

  logic [31:0] r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_state <= RST_SEED;
    else if (i_load) r_state <= i_seed;
    else if (i_adv)  r_state <= lfsr_step(r_state);
  end

  assign o_uni = r_state[15:0];

endmodule

// File: rtl/multihat_gen.sv
// N_CH-channel Irwin-Hall Gaussian generator: K_HAT LFSR uniforms summed per
// channel, 2-stage pipeline with valid/ready output. MULTIHAT_DBG_EN adds dbg_hat.
module multihat_gen import multihat_pkg::*; #(
  parameter int          N_CH      = 4,
  parameter int          K_HAT     = 4,
  parameter logic [31:0] SEED_BASE = 32'h1
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic                ap_start,
  output logic                ap_idle,
  input  logic                seed_load,
  input  logic [31:0]         seed_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [16*N_CH-1:0]  out_data,
  output logic [31:0]         sample_cnt
`ifdef MULTIHAT_DBG_EN
  ,
  output logic [16*K_HAT-1:0] dbg_hat
`endif
);

  localparam int N_HAT = N_CH * K_HAT;
  localparam int LG_K  = $clog2(K_HAT);
  localparam int SUM_W = 16 + LG_K;

  state_e                   r_state, w_state_nxt;
  logic [2:1]               r_vld_pipe;
  logic [N_CH-1:0][15:0]    r_data;
  logic [31:0]              r_sample_cnt;

  logic [N_HAT-1:0][31:0]   w_seed;
  logic [N_HAT-1:0][15:0]   w_uni;
  logic [N_CH-1:0][15:0]    w_chan;
  logic                     w_en, w_adv, w_load, w_xfer;

  // Whole pipeline (LFSRs included) freezes only when a beat is held unaccepted.
  assign w_xfer = r_vld_pipe[2] & out_ready;
  assign w_en   = ~r_vld_pipe[2] | out_ready;
  assign w_adv  = (r_state == ST_RUN) & w_en;
  assign w_load = (r_state == ST_IDLE) & seed_load;

  for (genvar h = 0; h < N_HAT; h++) begin : g_hat
    assign w_seed[h] = hat_seed(seed_in, h);
    multihat_lfsr #(.RST_SEED(hat_seed(SEED_BASE, h))) u_hat (
      .clk    (ap_clk),
      .rst_n  (ap_rst_n),
      .i_load (w_load),
      .i_seed (w_seed[h]),
      .i_adv  (w_adv),
      .o_uni  (w_uni[h])
    );
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [SUM_W-1:0] w_sum;
    always_comb begin
      w_sum = '0;
      for (int k = 0; k < K_HAT; k++)
        w_sum = w_sum + SUM_W'(w_uni[c*K_HAT+k]);
    end
    // Mean of K uniforms re-centred around zero; always fits in 16 bits.
    assign w_chan[c] = w_sum[LG_K +: 16] - 16'(OUT_OFFSET);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (ap_start) w_state_nxt = ST_RUN;
      ST_RUN:   if (!ap_start) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (ap_start)                 w_state_nxt = ST_RUN;
        else if (r_vld_pipe == '0)    w_state_nxt = ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_vld_pipe <= '0;
      r_data     <= '0;
    end else if (w_en) begin
      r_vld_pipe <= {r_vld_pipe[1], w_adv};
      if (r_vld_pipe[1]) r_data <= w_chan;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)   r_sample_cnt <= '0;
    else if (w_xfer) r_sample_cnt <= r_sample_cnt + 32'd1;
  end

`ifdef MULTIHAT_DBG_EN
  logic [K_HAT-1:0][15:0] r_dbg_hat;
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)                  r_dbg_hat <= '0;
    else if (w_en && r_vld_pipe[1]) r_dbg_hat <= w_uni[K_HAT-1:0];
  end
  assign dbg_hat = r_dbg_hat;
`endif

  assign ap_idle    = (r_state == ST_IDLE);
  assign out_valid  = r_vld_pipe[2];
  assign out_data   = r_data;
  assign sample_cnt = r_sample_cnt;

endmodule

// File: doc/multihat_gen.md
MULTIHAT_GEN -- requirements
Module: multihat_gen

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent Gaussian output channels (1..8).
REQ-002 SHALL have parameter K_HAT, default 4, uniform sources ("hats") summed per channel (1, 2, 4 or 8).
REQ-003 SHALL have parameter SEED_BASE, default 32'h1, seed applied at reset.
REQ-004 SHALL have port ap_clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port ap_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port ap_start  in  1  level run enable.
REQ-007 SHALL have port ap_idle  out  1  high when in IDLE.
REQ-008 SHALL have port seed_load  in  1  single-cycle reseed request.
REQ-009 SHALL have port seed_in  in  32  reseed value.
REQ-010 SHALL have port out_valid  out  1  out_data holds a sample.
REQ-011 SHALL have port out_ready  in  1  consumer accepts.
REQ-012 SHALL have port out_data  out  16*N_CH  channel c at bits [16c+15:16c], signed two's complement.
REQ-013 SHALL have port sample_cnt  out  32  accepted beats.

Function
REQ-014 Each hat h (global index h = c*K_HAT + k) SHALL be a 32-bit Galois LFSR: next = lsb ? (s>>1)^32'h80200003 : s>>1.
REQ-015 Hat uniform SHALL be bits [15:0] of the LFSR state after advance.
REQ-016 Channel sum S SHALL be unsigned, width 16+log2(K_HAT), no truncation.
REQ-017 Channel output SHALL be (S >> log2(K_HAT)) - 32768, taken as 16-bit signed; no overflow possible.
REQ-018 Pipeline SHALL be 2 stages: stage 1 LFSR advance, stage 2 registered sum/scale into out_data; out_valid asserts 2 cycles after first advance in RUN.
REQ-019 All LFSRs and both stages SHALL hold when out_valid=1 and out_ready=0; a beat transfers when out_valid & out_ready.
REQ-020 Full throughput of one beat/cycle SHALL be sustained while ap_start=1 and out_ready=1.
REQ-021 FSM states IDLE, RUN, DRAIN: IDLE->RUN on ap_start=1; RUN->DRAIN on ap_start=0; DRAIN->RUN on ap_start=1; DRAIN->IDLE when no stage valid.
REQ-022 LFSRs SHALL advance only in RUN; DRAIN only empties existing stages.
REQ-023 seed_load SHALL be honoured only in IDLE (ignored elsewhere): hat h loads seed_in ^ (h*32'h9E3779B9 mod 2^32); a zero result loads 32'h1.
REQ-024 seed_load and ap_start both high in IDLE: reseed takes effect and the FSM enters RUN; first advance uses the new seeds.
REQ-025 sample_cnt SHALL increment per transferred beat and wrap 32'hFFFFFFFF->0.

Reset
REQ-026 On ap_rst_n=0: FSM=IDLE, ap_idle=1, out_valid=0, out_data=0, sample_cnt=0, stage valids=0, LFSRs seeded from SEED_BASE by REQ-023 formula.
REQ-027 Reset asserted mid-RUN SHALL discard in-flight samples immediately.

Configuration
REQ-028 With MULTIHAT_DBG_EN defined, port dbg_hat  out  16*K_HAT SHALL carry channel 0's stage-1 uniforms, registered alongside out_data; without it the port and its registers SHALL not exist and function is unchanged.

Structure
REQ-029 Package multihat_pkg SHALL hold LFSR polynomial, golden-ratio seed constant, offset 32768, and the FSM state enum.
REQ-030 Sub-module multihat_lfsr (one 32-bit LFSR with load/advance/hold) SHALL be instantiated N_CH*K_HAT times.

Verification
REQ-031 N_CH=1, K_HAT=2, seed_load with seed_in=0, then ap_start=1, out_ready=1 -> first out_data = 16'hDE71, out_valid 2 cycles after RUN entry.
REQ-032 out_ready held 0 for 5 cycles mid-stream -> out_data stable, sample_cnt unchanged, sequence after release identical to unstalled reference.
REQ-033 ap_start dropped after 10 beats -> exactly the in-flight beats emitted, then ap_idle=1; restart continues LFSR sequence without repeat.
REQ-034 seed_load pulsed in RUN -> ignored, output sequence unchanged.
REQ-035 sample_cnt forced start near 32'hFFFFFFFE via 3 transfers -> wraps to 32'h1.
REQ-036 ap_rst_n asserted mid-stream -> out_valid=0 same cycle; restart reproduces the SEED_BASE sequence from its first sample.
